transmitting: RTL and testbench
===============================

# transmitting

Serial transmitter paired with the `receiving` block: it accepts a 7-bit character on a one-cycle load strobe and shifts it onto a single line as a 10-bit asynchronous frame. The frame is start 0, 7 data bits LSB first, even parity, stop 1. The line rests at 1 when idle. Each bit is held for 16 clocks, which is the bit period `receiving` samples at. It sits on the transmit side of the serial link and can be looped directly into `receiving` in the system testbench.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles each frame bit is held; must be ≥ 2.
- `DATA_BITS`, 7: data bits per frame; frame length is `DATA_BITS` + 3.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `data_in` input `DATA_BITS`: character to send; sampled only on an accepted load.
- `load` input 1: request to send `data_in`; accepted only in a cycle where `busy` = 0.
- `data_out` output 1: serial line, registered.
- `busy` output 1: high from the cycle after an accepted load through the last stop-bit clock.
- `charSent` output 1: one-cycle pulse in the first cycle after a frame completes.

## Operation
- Reset values: `data_out` = 1, `busy` = 0, `charSent` = 0. State is IDLE, all counters 0, shift register 0.
- FSM states:
  - IDLE: line 1. If `load` = 1, latch `data_in` into the shift register, compute parity = XOR of the latched bits (even parity), zero both counters, go to START.
  - START: line 0 for `CLKS_PER_BIT` clocks, then go to DATA.
  - DATA: line = shift register bit 0. Shift right every `CLKS_PER_BIT` clocks. After `DATA_BITS` bits, go to PARITY.
  - PARITY: line = latched parity for `CLKS_PER_BIT` clocks, then go to STOP.
  - STOP: line 1 for `CLKS_PER_BIT` clocks, then go to IDLE and set `charSent` = 1 for exactly one cycle.
- Counters:
  - Tick counter is `$clog2(CLKS_PER_BIT)` bits and wraps from `CLKS_PER_BIT`−1 to 0 at each bit boundary.
  - Bit counter is 3 bits and counts data bits only.
- `load` while `busy` = 1 is ignored: no queueing, no error flag. `data_in` changes mid-frame have no effect.
- Back-to-back: `busy` is 0 in the `charSent` cycle. A `load` in that cycle is accepted, and the next start bit begins on the following edge with zero idle gap.
- Reset mid-frame: the line returns to 1 immediately (asynchronous). The frame is aborted, `charSent` is not pulsed, and the block is ready for `load` on the first edge after reset deasserts.

## Timing
- Let edge E0 be the edge that samples `load` = 1 in IDLE.
- After E0: `data_out` = 0, `busy` = 1.
- Bit k (0 = start, 9 = stop) occupies the cycles after edges E0+16k through E0+16k+15.
- Data bit i is on the line after edges E0+16(i+1) through E0+16(i+1)+15.
- After E0+160: IDLE, `data_out` = 1, `busy` = 0, `charSent` = 1. After E0+161: `charSent` = 0.
- Load-to-`charSent` latency is 160 cycles, i.e. (`DATA_BITS`+3)·`CLKS_PER_BIT`.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared definitions header, included by both `transmitting` and `receiving`:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP; 3 bits).
  - Frame constants: `DATA_BITS` = 7, `FRAME_BITS` = 10, `CLKS_PER_BIT` = 16.
  - Line levels: IDLE_LEVEL = 1, START_LEVEL = 0.
- One sub-module, `bit_timer`:
  - Function: tick counter producing a one-cycle `bitDone` when the count reaches `CLKS_PER_BIT`−1.
  - Controls: cleared by `reset` or by a `clear` input driven on load.
  - Reusable by `receiving` for its sampling counter.
- The top level holds the FSM, shift register, parity flop and output registers.

## Test plan
- Reset: hold `reset` high for 2 cycles with `load` = 1 → `data_out` = 1, `busy` = 0, `charSent` = 0 throughout. No frame starts until after deassert.
- Single frame: `data_in` = 7'h4B, `load` pulsed one cycle → line reads 0,1,1,0,1,0,0,1,0,1 (start, LSB-first data, parity 0, stop), each bit held exactly 16 cycles. `charSent` pulses 160 cycles after the load edge.
- Odd-weight data: `data_in` = 7'h0D → line reads 0,1,0,1,1,0,0,0,1,1 (parity 1). Then 7'h00 → parity 0, and 7'h7F → parity 1.
- Busy rejection and data hold: a second `load` with 7'h55 at cycle 40 of a 7'h4B frame → no effect, frame unchanged, one `charSent`. Toggling `data_in` mid-frame leaves the line unchanged.
- Back-to-back and loopback: `load` asserted in the `charSent` cycle with 7'h0D after 7'h4B → the second start bit follows the stop bit with no idle cycle. `data_out` wired to `receiving`'s input → `receiving` reports both characters with parity and stop bits as sent.
- Reset mid-frame: assert `reset` during data bit 3 → `data_out` = 1 within the same cycle, no `charSent`. A fresh 7'h4B frame sent after deassert is bit-exact.

Source files
------------

// File: rtl/transmitting_pkg.sv
// Shared definitions for the serial link: transmitter FSM encoding, frame constants and
// line levels. Also intended for inclusion by the paired receiver.
package transmitting_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam int unsigned DataBits   = 7;
  localparam int unsigned FrameBits  = DataBits + 3;
  localparam int unsigned ClksPerBit = 16;

  localparam logic IdleLevel  = 1'b1;
  localparam logic StartLevel = 1'b0;

endpackage

// File: rtl/transmitting_if.sv
// Character load handshake plus serial line and status outputs of the transmitter.
interface transmitting_if #(
  parameter int unsigned DATA_BITS = transmitting_pkg::DataBits
);
  logic [DATA_BITS-1:0] data_in;
  logic                 load;
  logic                 data_out;
  logic                 busy;
  logic                 charSent;

  modport master (
    output data_in,
    output load,
    input  data_out,
    input  busy,
    input  charSent
  );

  modport slave (
    input  data_in,
    input  load,
    output data_out,
    output busy,
    output charSent
  );
endinterface

// File: rtl/transmitting_bit_timer.sv
// Bit-period tick counter: wraps every CLKS_PER_BIT clocks and flags the last clock of the period.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = transmitting_pkg::ClksPerBit
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitDone
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign bitDone = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || bitDone) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/transmitting.sv
// Serial transmitter: start bit, DATA_BITS data bits LSB first, even parity, stop bit,
// each held CLKS_PER_BIT clocks. All outputs come straight from flops.
module transmitting
  import transmitting_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBit,
  parameter int unsigned DATA_BITS    = DataBits
) (
  input  logic          clk,
  input  logic          reset,
  transmitting_if.slave tx
);
  localparam int unsigned BitCntW = 3;

  tx_state_e            state_d, state_q;
  logic [DATA_BITS-1:0] shreg_d, shreg_q;
  logic [BitCntW-1:0]   bit_cnt_d, bit_cnt_q;
  logic                 parity_d, parity_q;
  logic                 data_out_d, data_out_q;
  logic                 busy_d, busy_q;
  logic                 char_sent_d, char_sent_q;
  logic                 accept;
  logic                 bit_done;

  assign accept = (state_q == StIdle) && tx.load;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .bitDone(bit_done)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    parity_d    = parity_q;
    char_sent_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d   = tx.data_in;
          parity_d  = ^tx.data_in;
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_done) state_d = StData;
      end
      StData: begin
        if (bit_done) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) state_d = StParity;
        end
      end
      StParity: begin
        if (bit_done) state_d = StStop;
      end
      StStop: begin
        if (bit_done) begin
          state_d     = StIdle;
          char_sent_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so the registered output tracks the FSM exactly.
  always_comb begin
    data_out_d = IdleLevel;
    unique case (state_d)
      StStart:  data_out_d = StartLevel;
      StData:   data_out_d = shreg_d[0];
      StParity: data_out_d = parity_d;
      default:  data_out_d = IdleLevel;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      data_out_q  <= IdleLevel;
      busy_q      <= 1'b0;
      char_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      char_sent_q <= char_sent_d;
    end
  end

  assign tx.data_out = data_out_q;
  assign tx.busy     = busy_q;
  assign tx.charSent = char_sent_q;
endmodule

// File: tb/tb_transmitting.sv
// Scoreboard bench for transmitting: stimulus queues expected frames, a negedge monitor
// checks every line cycle, busy, and the charSent pulse position.
module tb_transmitting;
  localparam int unsigned Cpb   = 16;
  localparam int unsigned Frame = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  transmitting_if #(.DATA_BITS(7)) tx ();

  transmitting #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tx   (tx)
  );

  int checks   = 0;
  int failures = 0;

  // Expected line levels, bit k of the entry = frame bit k (0 = start, 9 = stop).
  logic [Frame-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor state
  bit               mon_active = 1'b0;
  int               mon_cyc    = 0;
  int               bit_errs   = 0;
  logic [Frame-1:0] mon_exp    = '0;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
      check("reset data_out", int'(tx.data_out), 1);
      check("reset busy", int'(tx.busy), 0);
      check("reset charSent", int'(tx.charSent), 0);
    end else if (mon_active) begin
      if (mon_cyc < int'(Frame * Cpb)) begin
        if (tx.data_out !== mon_exp[mon_cyc / Cpb] || tx.busy !== 1'b1 || tx.charSent !== 1'b0)
          bit_errs++;
        if (mon_cyc % Cpb == Cpb - 1) begin
          check($sformatf("frame bit %0d bad cycles", mon_cyc / Cpb), bit_errs, 0);
          bit_errs = 0;
        end
        mon_cyc++;
      end else begin
        check("charSent at load+160", int'(tx.charSent), 1);
        check("busy low in charSent cycle", int'(tx.busy), 0);
        check("line idle in charSent cycle", int'(tx.data_out), 1);
        mon_active = 1'b0;
      end
    end else begin
      if (tx.busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected frame start", 1, 0);
        end else begin
          mon_exp    = exp_q.pop_front();
          mon_active = 1'b1;
          mon_cyc    = 0;
          bit_errs   = 0;
          if (tx.data_out !== mon_exp[0]) bit_errs++;
          mon_cyc = 1;
        end
      end else if (tx.charSent === 1'b1) begin
        check("spurious charSent", 1, 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] d, input logic [Frame-1:0] e);
    exp_q.push_back(e);
    tx.data_in = d;
    tx.load    = 1'b1;
    step();
    tx.load    = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("frame completion timeout", 1, 0);
    step();
  endtask

  // Hand-derived frames, written k9..k0
  localparam logic [Frame-1:0] F4B = 10'b1010010110;
  localparam logic [Frame-1:0] F0D = 10'b1100011010;
  localparam logic [Frame-1:0] F00 = 10'b1000000000;
  localparam logic [Frame-1:0] F7F = 10'b1111111110;

  initial begin
    tx.data_in = 7'h4B;
    tx.load    = 1'b1;
    reset      = 1'b1;
    step();
    step();
    reset   = 1'b0;
    tx.load = 1'b0;
    repeat (3) step();

    send(7'h4B, F4B);
    wait_done();
    send(7'h0D, F0D);
    wait_done();
    send(7'h00, F00);
    wait_done();
    send(7'h7F, F7F);
    wait_done();

    // Rejected load and data_in churn mid-frame.
    send(7'h4B, F4B);
    repeat (38) step();
    tx.data_in = 7'h55;
    tx.load    = 1'b1;
    step();
    tx.load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tx.data_in = 7'(i * 37);
      step();
    end
    wait_done();

    // Back-to-back: load issued in the charSent cycle.
    send(7'h4B, F4B);
    begin
      int n = 0;
      while (tx.charSent !== 1'b1 && n < 300) begin
        step();
        n++;
      end
      if (n >= 300) check("charSent wait timeout", 1, 0);
    end
    send(7'h0D, F0D);
    check("b2b start bit line", int'(tx.data_out), 0);
    check("b2b busy", int'(tx.busy), 1);
    wait_done();

    // Reset during data bit 3 (frame cycles 64..79).
    send(7'h4B, F4B);
    repeat (70) step();
    reset = 1'b1;
    #1;
    check("async reset line", int'(tx.data_out), 1);
    check("async reset busy", int'(tx.busy), 0);
    step();
    reset = 1'b0;
    repeat (200) step();
    send(7'h4B, F4B);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
